smg_scan: RTL
=============

# smg_scan

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display. It generates the digit select `sel[1:0]` and the digit code `key[3:0]` consumed by the combinational segment/digit decoder. It accepts a 16-bit packed value (4 nibbles, digit 3 most significant) through a valid/ready handshake and double-buffers it. The displayed value changes only at frame boundaries, so the display never shows a mix of old and new digits.

## Interface

- `DIV_CNT`, default 50000: clock cycles per digit slot (1 ms at 50 MHz); legal range 2..2^32-1.
- `BLANK_LZ`, default 1: 1 = blank leading zeros on digits 3..1; 0 = show all nibbles.

- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `data_in`  in  16  packed value; digit n = `data_in[4n+3:4n]`.
- `data_vld`  in  1  `data_in` is valid.
- `data_rdy`  out  1  block can accept a value (= not pending).
- `sel`  out  2  current digit slot, 0..3 (registered).
- `key`  out  4  code for the current slot; 0–9 digit, 4'hA–4'hE passed through, 4'hF = blank (registered).
- `frame_done`  out  1  one-cycle pulse when slot 3 ends.

## Operation

- Divider `cnt` counts 0..DIV_CNT-1 and wraps. `tick` = (`cnt` == DIV_CNT-1).
- On `tick`, `sel` advances 0→1→2→3→0. A tick with `sel`==3 is a **frame wrap**.
- Buffers:
  - `shadow[15:0]` holds an accepted value.
  - `active[15:0]` holds the displayed value.
  - `pending` flags that `shadow` is waiting to be committed.
- Accept: when `data_vld` && `data_rdy`, set `shadow` <= `data_in` and `pending` <= 1. `data_rdy` = !`pending`.
- While `pending`, `data_vld` is ignored. The source must hold the value until `data_rdy` returns.
- Commit: on a frame wrap with `pending`==1, set `active` <= `shadow` and `pending` <= 0.
- A frame wrap with `pending`==0 leaves `active` unchanged.
- Simultaneous accept and frame wrap: the accept happens and the wrap sees `pending`==0, so no commit. The value commits at the following frame wrap.
- `key` derivation, for next slot s and next active value A:
  - nibble = A[4s+3:4s].
  - With BLANK_LZ=1, digit s (s≥1) shows 4'hF when A digits 3..s are all zero. Digit 0 is never blanked.
  - Nibbles 4'hA–4'hF pass unchanged.
- `sel` and `key` are updated in the same clock edge. `key` always matches `sel` and `active` in that cycle.
- `frame_done` is a registered pulse, high for the one cycle after a frame wrap edge (coincident with `sel` returning to 0).

## Timing

- Reset values:
  - `cnt`=0, `sel`=0, `active`=0, `shadow`=0, `pending`=0.
  - `key`=4'h0 (digit 0 of zero is not blanked).
  - `frame_done`=0, `data_rdy`=1.
- Reset is asynchronous: all state clears immediately on `rst_n` low, mid-frame or mid-pending. A pending value is discarded.
- First `tick` occurs DIV_CNT cycles after reset release. `sel`=1 is visible from cycle DIV_CNT+1.
- Each slot is exactly DIV_CNT cycles; a frame is 4·DIV_CNT cycles.
- `data_rdy` falls the cycle after accept. It rises the cycle after the commit edge.
- Accept-to-display latency: at most 4·DIV_CNT+1 cycles, or 8·DIV_CNT+1 in the simultaneous accept-and-wrap case.
- Committed digit 0 appears in `key` in the same cycle `sel` returns to 0.

## Test plan

All scenarios use DIV_CNT=4.

- **Reset.** Release reset, BLANK_LZ=1 → `sel`=0, `key`=0, `data_rdy`=1, `frame_done`=0. After 4 cycles, `sel`=1, `key`=F. Slots 2 and 3 also show `key`=F.
- **Load 16'h1234.** Accept → `data_rdy`=0 the next cycle. At the next wrap, `frame_done`=1 with `sel`=0, `key`=4. Then slots 1, 2, 3 show `key` = 3, 2, 1. `data_rdy`=1 after the commit.
- **Blanking.** Load 16'h0050 → slot keys 0, 5, F, F. With BLANK_LZ=0 → 0, 5, 0, 0. Load 16'h00A0 → A, ... no: keys 0, A, F, F (nonzero nibble stops blanking).
- **Back-pressure.** Hold `data_vld`=1 with 16'h1111 while 16'h2222 is pending → 16'h1111 is not accepted until `data_rdy` returns. 16'h2222 is displayed first, then 16'h1111 one frame later.
- **Accept at wrap.** Accept 16'h9876 in the same cycle as a frame wrap → no commit at that wrap. `key` at `sel`=0 shows 6 only after the next wrap, 16 cycles later.
- **Reset mid-frame.** Pull `rst_n` low while `sel`=2 with a value pending → outputs return to reset values asynchronously. After release, `active`=0 and the pending value is never displayed.

Source files
------------

// File: rtl/smg_scan_if.sv
// Value-load handshake between a data source and the smg_scan display controller.
interface smg_scan_if;
  logic [15:0] data_in;
  logic        data_vld;
  logic        data_rdy;

  // Source side: presents a packed 4-digit value and watches for readiness.
  modport master (output data_in, output data_vld, input data_rdy);
  // Display side: consumes the value and reports whether it can take another.
  modport slave  (input data_in, input data_vld, output data_rdy);
endinterface

// File: rtl/smg_scan.sv
// Four-digit seven-segment scan controller.
// Cycles through the digit slots and emits a registered (sel, key) pair.
// Incoming values are double-buffered, so the display only ever changes at a
// frame boundary and never shows a mix of old and new digits.
module smg_scan #(
  parameter int unsigned DIV_CNT  = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  smg_scan_if.slave    bus,
  output logic [1:0]   sel,
  output logic [3:0]   key,
  output logic         frame_done
);

  logic [31:0] r_cnt;
  logic [1:0]  r_sel;
  logic [3:0]  r_key;
  logic        r_frame_done;
  logic [15:0] r_shadow;
  logic [15:0] r_active;
  logic        r_pending;

  logic        w_tick;
  logic        w_wrap;
  logic        w_accept;
  logic        w_commit;
  logic [1:0]  w_sel_next;
  logic [15:0] w_active_next;
  logic [3:0]  w_lz;
  logic [3:0]  w_nib;
  logic [3:0]  w_key_next;

  assign w_tick   = (r_cnt == DIV_CNT - 32'd1);
  assign w_wrap   = w_tick && (r_sel == 2'd3);
  assign w_accept = bus.data_vld && !r_pending;
  // An accept always sees pending low, so it can never coincide with a commit;
  // a value accepted on a wrap edge therefore waits for the next wrap.
  assign w_commit = w_wrap && r_pending;

  assign w_sel_next    = w_tick ? r_sel + 2'd1 : r_sel;
  assign w_active_next = w_commit ? r_shadow : r_active;

  // w_lz[s]: every digit from 3 down to s is zero; digit 0 is never blanked.
  assign w_lz[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
      assign w_lz[gi] = (w_active_next[15:4*gi] == '0);
    end
  endgenerate

  // Key for the slot being entered, derived from the value that will be active,
  // so key always agrees with sel and active in the same cycle.
  always_comb begin
    w_nib      = w_active_next[4*w_sel_next +: 4];
    w_key_next = w_nib;
    if (BLANK_LZ && w_lz[w_sel_next]) begin
      w_key_next = 4'hF;
    end
  end

  // Slot divider, slot select, double buffer and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_sel        <= '0;
      r_key        <= 4'h0;
      r_frame_done <= 1'b0;
      r_shadow     <= '0;
      r_active     <= '0;
      r_pending    <= 1'b0;
    end else begin
      r_cnt        <= w_tick ? '0 : r_cnt + 32'd1;
      r_sel        <= w_sel_next;
      r_key        <= w_key_next;
      r_frame_done <= w_wrap;
      r_active     <= w_active_next;
      if (w_accept) begin
        r_shadow  <= bus.data_in;
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign bus.data_rdy = !r_pending;
  assign sel          = r_sel;
  assign key          = r_key;
  assign frame_done   = r_frame_done;

endmodule
